// File: rtl/noc_host_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ host requesters into one router injection port.
// Define NOC_ARB_STATS_EN to add a saturating 16-bit injection counter output (inj_count).
module noc_host_arbiter #(
    parameter int PACKET_SIZE = 8,
    parameter int NUM_REQ     = 4,
    parameter int REQ_BITS    = 2,
    parameter int INJ_GAP     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [PACKET_SIZE*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           host_full,
    output logic [PACKET_SIZE-1:0]         host_data,
    output logic                           host_en,
`ifdef NOC_ARB_STATS_EN
    output logic [15:0]                    inj_count,
`endif
    output logic [REQ_BITS-1:0]            grant_id
);

    typedef enum logic {IDLE, GAP} state_t;

    state_t                  state_q, state_d;
    logic [REQ_BITS-1:0]     rr_ptr_q, rr_ptr_d;
    logic [3:0]              gap_cnt_q, gap_cnt_d;
    logic                    host_en_q, host_en_d;
    logic [PACKET_SIZE-1:0]  host_data_q, host_data_d;
    logic [REQ_BITS-1:0]     grant_id_q, grant_id_d;

    logic                    found;
    logic [REQ_BITS-1:0]     grant_idx;

    // Search upward from rr_ptr, wrapping, for the first pending requester.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        if (state_q == IDLE && !host_full) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                if (!found && req_valid[(int'(rr_ptr_q) + off) % NUM_REQ]) begin
                    found     = 1'b1;
                    grant_idx = REQ_BITS'((int'(rr_ptr_q) + off) % NUM_REQ);
                end
            end
            if (found) begin
                req_ready = NUM_REQ'(1) << grant_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gap_cnt_d   = gap_cnt_q;
        host_en_d   = 1'b0;
        host_data_d = host_data_q;
        grant_id_d  = grant_id_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    host_en_d   = 1'b1;
                    host_data_d = req_data[int'(grant_idx)*PACKET_SIZE +: PACKET_SIZE];
                    grant_id_d  = grant_idx;
                    rr_ptr_d    = (grant_idx == REQ_BITS'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                    if (INJ_GAP > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = 4'(INJ_GAP);
                    end
                end
            end
            GAP: begin
                // Host backpressure is deliberately ignored here; the gap runs on schedule.
                if (gap_cnt_q <= 4'd1) begin
                    state_d   = IDLE;
                    gap_cnt_d = 4'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gap_cnt_q   <= 4'd0;
            host_en_q   <= 1'b0;
            host_data_q <= '0;
            grant_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gap_cnt_q   <= gap_cnt_d;
            host_en_q   <= host_en_d;
            host_data_q <= host_data_d;
            grant_id_q  <= grant_id_d;
        end
    end

    assign host_en   = host_en_q;
    assign host_data = host_data_q;
    assign grant_id  = grant_id_q;

`ifdef NOC_ARB_STATS_EN
    logic [15:0] inj_count_q, inj_count_d;

    always_comb begin
        inj_count_d = inj_count_q;
        if (host_en_q && inj_count_q != 16'hFFFF) begin
            inj_count_d = inj_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_count_q <= 16'd0;
        end else begin
            inj_count_q <= inj_count_d;
        end
    end

    assign inj_count = inj_count_q;
`endif

endmodule

// File: tb/tb_noc_host_arbiter.sv
// Directed bench for noc_host_arbiter: one instance with INJ_GAP=1 and one with INJ_GAP=0 share inputs.
// Stats checks are compiled only when NOC_ARB_STATS_EN is defined.
module tb_noc_host_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        host_full;

    logic [3:0]  ready1, ready0;
    logic [7:0]  hdata1, hdata0;
    logic        hen1, hen0;
    logic [1:0]  gid1, gid0;
`ifdef NOC_ARB_STATS_EN
    logic [15:0] cnt1, cnt0;
`endif

    int checks = 0;
    int errors = 0;

    noc_host_arbiter #(.PACKET_SIZE(8), .NUM_REQ(4), .REQ_BITS(2), .INJ_GAP(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready1), .host_full(host_full), .host_data(hdata1), .host_en(hen1),
`ifdef NOC_ARB_STATS_EN
        .inj_count(cnt1),
`endif
        .grant_id(gid1)
    );

    noc_host_arbiter #(.PACKET_SIZE(8), .NUM_REQ(4), .REQ_BITS(2), .INJ_GAP(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready0), .host_full(host_full), .host_data(hdata0), .host_en(hen0),
`ifdef NOC_ARB_STATS_EN
        .inj_count(cnt0),
`endif
        .grant_id(gid0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic full);
        req_valid = valid;
        host_full = full;
        #1;
    endtask

    task automatic applyReset();
        rst       = 1'b1;
        req_valid = 4'b0000;
        host_full = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Expected data for requester i, matching the req_data image below.
    function automatic logic [7:0] dataOf(input int i);
        logic [31:0] img;
        img = 32'h13A5_1110;
        return img[i*8 +: 8];
    endfunction

    initial begin
        rst       = 1'b0;
        req_valid = 4'b0000;
        host_full = 1'b0;
        req_data  = 32'h13A5_1110;

        // Reset state
        applyReset();
        checkOutput("rst_host_en", 32'(hen1), 32'h0);
        checkOutput("rst_host_data", 32'(hdata1), 32'h0);
        checkOutput("rst_grant_id", 32'(gid1), 32'h0);
        checkOutput("rst_ready_idle", 32'(ready1), 32'h0);

        // Single requester, then rr_ptr must point at 3
        applyStimulus(4'b0100, 1'b0);
        checkOutput("single_ready", 32'(ready1), 32'b0100);
        tick();
        checkOutput("single_en", 32'(hen1), 32'h1);
        checkOutput("single_data", 32'(hdata1), 32'hA5);
        checkOutput("single_gid", 32'(gid1), 32'h2);
        applyStimulus(4'b1111, 1'b0);
        checkOutput("gap_ready_zero", 32'(ready1), 32'h0);
        tick();
        checkOutput("gap_en_low", 32'(hen1), 32'h0);
        checkOutput("gap_data_hold", 32'(hdata1), 32'hA5);
        checkOutput("rrptr3_ready", 32'(ready1), 32'b1000);
        tick();
        checkOutput("rrptr3_gid", 32'(gid1), 32'h3);

        // Round robin with all valid, INJ_GAP=1
        applyReset();
        applyStimulus(4'b1111, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            checkOutput($sformatf("rr_en_%0d", i), 32'(hen1), 32'(i % 2));
            if (i % 2 == 1) begin
                checkOutput($sformatf("rr_gid_%0d", i), 32'(gid1), 32'(((i - 1) / 2) % 4));
                checkOutput($sformatf("rr_data_%0d", i), 32'(hdata1), 32'(dataOf(((i - 1) / 2) % 4)));
            end
        end

        // Backpressure for 5 cycles, then release
        applyReset();
        applyStimulus(4'b0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_ready_%0d", i), 32'(ready1), 32'h0);
            tick();
            checkOutput($sformatf("bp_en_%0d", i), 32'(hen1), 32'h0);
        end
        applyStimulus(4'b0001, 1'b0);
        checkOutput("bp_release_ready", 32'(ready1), 32'b0001);
        tick();
        checkOutput("bp_release_en", 32'(hen1), 32'h1);
        checkOutput("bp_release_gid", 32'(gid1), 32'h0);
        // host_full rising during the gap only delays the next grant
        applyStimulus(4'b0001, 1'b1);
        tick();
        checkOutput("gapfull_ready", 32'(ready1), 32'h0);
        tick();
        checkOutput("gapfull_en", 32'(hen1), 32'h0);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("gapfull_release", 32'(ready1), 32'b0001);

        // Back-to-back injection on the INJ_GAP=0 instance
        applyReset();
        applyStimulus(4'b0011, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("b2b_en_%0d", i), 32'(hen0), 32'h1);
            checkOutput($sformatf("b2b_gid_%0d", i), 32'(gid0), 32'(i % 2));
        end
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("b2b_en_done", 32'(hen0), 32'h0);

        // Reset pulsed during an accept cycle
        applyReset();
        applyStimulus(4'b0010, 1'b0);
        tick();
        checkOutput("mid_first_gid", 32'(gid1), 32'h1);
        applyStimulus(4'b0000, 1'b0);
        tick();
        applyStimulus(4'b0110, 1'b0);
        checkOutput("mid_ready_pre", 32'(ready1), 32'b0100);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_async_en", 32'(hen1), 32'h0);
        checkOutput("mid_async_data", 32'(hdata1), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("mid_after_en", 32'(hen1), 32'h0);
        checkOutput("mid_after_ready", 32'(ready1), 32'b0010);
        tick();
        checkOutput("mid_next_en", 32'(hen1), 32'h1);
        checkOutput("mid_next_gid", 32'(gid1), 32'h1);

`ifdef NOC_ARB_STATS_EN
        // Saturating injection counter, one injection per cycle on the INJ_GAP=0 instance
        applyReset();
        checkOutput("stats_rst", 32'(cnt0), 32'h0);
        applyStimulus(4'b0001, 1'b0);
        for (int i = 0; i < 101; i++) tick();
        checkOutput("stats_100", 32'(cnt0), 32'd100);
        for (int i = 0; i < 69900; i++) tick();
        checkOutput("stats_sat", 32'(cnt0), 32'hFFFF);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("stats_nowrap", 32'(cnt0), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
